// File: rtl/activation_skew_pkg.sv
// Shared types and elaboration-time helpers for the activation skew buffer.
package activation_skew_pkg;

  // Drain controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } skew_state_e;

  // Ceiling log2. Never returns less than 1, so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result == 0) ? 1 : result;
  endfunction

  // Register depth of row i.
  // dir=0 skews: row i waits i cycles.
  // dir=1 deskews: row i waits size-1-i cycles.
  function automatic int skew_depth(input int i, input int size, input bit dir);
    return dir ? (size - 1 - i) : i;
  endfunction

endpackage

// File: rtl/activation_skew_buffer_row.sv
// One channel of the skew buffer: a DEPTH-stage {valid, data} shift line.
// A DEPTH of 0 gives a purely combinational pass-through.
module skew_row #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             line_busy
);

  if (DEPTH == 0) begin : g_pass
    // No registers in this row, so the clock, reset and enable are not used here.
    logic unused_pass;
    assign unused_pass = ^{clk, rst, en};
    assign out_valid   = in_valid;
    assign out_data    = in_data;
    assign line_busy   = 1'b0;
  end else begin : g_line
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Shift the line one stage per enabled cycle.
    // Data on a bubble is stored as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= '0;
        for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
      end else if (en) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= in_valid ? in_data : '0;
        for (int s = 1; s < DEPTH; s++) begin
          valid_q[s] <= valid_q[s-1];
          data_q[s]  <= data_q[s-1];
        end
      end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign line_busy = |valid_q;
  end

endmodule

// File: rtl/activation_skew_buffer.sv
// Array-edge activation skew buffer.
// It turns a parallel activation vector into a 45-degree wavefront when SKEW_DIR=0.
// It realigns such a wavefront into a parallel vector when SKEW_DIR=1.
// test_mode bypasses the delay lines entirely.
// A flush request drains in-flight data before returning to idle.
//
// Handshake: a vector is taken on any cycle where in_valid & in_ready.
// in_ready is low only while draining.
// There is no output backpressure; out_valid is a per-row qualifier.
// en=0 freezes every line, the counter and the FSM.
module activation_skew_buffer
  import activation_skew_pkg::*;
#(
  parameter int SYSTOLIC_SIZE    = 8,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int SKEW_DIR         = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic                                      test_mode,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_in_flat,
  output logic [SYSTOLIC_SIZE-1:0]                  out_valid,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0] activation_out_flat,
  output logic                                      busy,
  output logic                                      drain_done,
  output logic [1:0]                                fsm_state
);

  localparam int N  = SYSTOLIC_SIZE;
  localparam int W  = ACTIVATION_WIDTH;
  localparam int CW = clog2(N);
  // Last count value of a drain; the deepest line empties after N-1 enabled cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 2);

  skew_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drain_done_q;
  logic          drain_fire;
  logic          in_accept;

  logic [N-1:0]  row_valid;
  logic [N-1:0]  row_busy;
  logic [W-1:0]  row_data [N];

  assign in_ready   = (state_q != ST_DRAIN);
  assign in_accept  = in_valid & in_ready;
  assign busy       = (|row_busy) | (state_q == ST_DRAIN);
  assign drain_done = drain_done_q;
  assign fsm_state  = state_q;

  // Next-state logic for IDLE -> RUN -> DRAIN -> IDLE; nothing moves without en.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drain_fire = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (in_accept) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (flush) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            state_d    = ST_IDLE;
            drain_fire = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, drain counter and the registered completion pulse.
  // drain_done is a single-clock pulse even if en drops right after completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_done_q <= drain_fire;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_rows
    localparam int DEPTH = skew_depth(i, N, SKEW_DIR != 0);

    skew_row #(
      .DEPTH (DEPTH),
      .WIDTH (W)
    ) u_row (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_accept),
      .in_data   (activation_in_flat[i*W +: W]),
      .out_valid (row_valid[i]),
      .out_data  (row_data[i]),
      .line_busy (row_busy[i])
    );
  end

  // Output select: delayed line or direct bypass; bubbles always present zero data.
  always_comb begin
    out_valid           = '0;
    activation_out_flat = '0;
    for (int i = 0; i < N; i++) begin
      out_valid[i] = test_mode ? in_accept : row_valid[i];
      if (out_valid[i]) begin
        activation_out_flat[i*W +: W] = test_mode ? activation_in_flat[i*W +: W] : row_data[i];
      end
    end
  end

endmodule

// File: tb/tb_activation_skew_buffer.sv
// Bench for activation_skew_buffer.
// Two instances, one skewing and one deskewing, share the same stimulus.
// Each accepted vector is scheduled per row with the enabled-cycle count at which it must appear.
// A negedge monitor compares every row and every status output against that schedule.
module tb_activation_skew_buffer;
  import activation_skew_pkg::*;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TOT = N * W;

  // Clock, stimulus and DUT outputs.
  logic           clk = 1'b0;
  logic           rst, en, test_mode, flush, in_valid;
  logic [TOT-1:0] act_in;

  logic           in_ready_o     [2];
  logic [N-1:0]   out_valid_o    [2];
  logic [TOT-1:0] act_out_o      [2];
  logic           busy_o         [2];
  logic           drain_done_o   [2];
  logic [1:0]     fsm_o          [2];

  always #5 clk = ~clk;

  activation_skew_buffer #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(W), .SKEW_DIR(0)) u_dut_skew (
    .clk(clk), .rst(rst), .en(en), .test_mode(test_mode), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_o[0]), .activation_in_flat(act_in),
    .out_valid(out_valid_o[0]), .activation_out_flat(act_out_o[0]),
    .busy(busy_o[0]), .drain_done(drain_done_o[0]), .fsm_state(fsm_o[0])
  );

  activation_skew_buffer #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(W), .SKEW_DIR(1)) u_dut_deskew (
    .clk(clk), .rst(rst), .en(en), .test_mode(test_mode), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_o[1]), .activation_in_flat(act_in),
    .out_valid(out_valid_o[1]), .activation_out_flat(act_out_o[1]),
    .busy(busy_o[1]), .drain_done(drain_done_o[1]), .fsm_state(fsm_o[1])
  );

  // Scoreboard: per (dut,row) queue of {due enabled-cycle, data}.
  typedef struct packed {
    int         due;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q [2*N][$];
  bit   seen  [2*N];

  int checks   = 0;
  int failures = 0;

  // Reference model of the control behaviour.
  // mode: 0 idle, 1 run, 2 drain.
  int ecount     = 0;
  int mode       = 0;
  int drain_left = 0;
  bit exp_done   = 1'b0;
  bit acc_hist[$];
  bit mon_on     = 1'b0;

  // Values driven during the cycle that the next edge will sample.
  bit p_rst = 1'b1, p_en = 1'b0, p_flush = 1'b0, p_acc = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endfunction

  function automatic int depth_of(input int dut, input int row);
    return (dut == 0) ? row : (N - 1 - row);
  endfunction

  function automatic bit busy_model();
    bit b;
    int sz;
    b  = (mode == 2);
    sz = acc_hist.size();
    for (int j = 1; j < N; j++) begin
      if (sz >= j && acc_hist[sz-j]) b = 1'b1;
    end
    return b;
  endfunction

  // Advance the model across one rising edge using the values held before it.
  task automatic model_edge();
    if (p_rst) begin
      ecount     = 0;
      mode       = 0;
      drain_left = 0;
      exp_done   = 1'b0;
      acc_hist.delete();
      for (int k = 0; k < 2*N; k++) begin
        exp_q[k].delete();
        seen[k] = 1'b0;
      end
      mon_on = 1'b1;
    end else if (p_en) begin
      ecount++;
      acc_hist.push_back(p_acc);
      exp_done = (mode == 2) && (drain_left == 1);
      case (mode)
        0: if (p_acc) mode = 1;
        1: if (p_flush) begin mode = 2; drain_left = N - 1; end
        default: begin
          drain_left--;
          if (drain_left == 0) mode = 0;
        end
      endcase
    end else begin
      exp_done = 1'b0;
    end
  endtask

  // Driver: one clock cycle of stimulus.
  // An upstream never offers data while stalled, so v is gated by e.
  task automatic drive(input bit r, input bit e, input bit tm, input bit f, input bit v,
                       input logic [TOT-1:0] d);
    bit   acc;
    exp_t item;
    @(posedge clk);
    model_edge();
    #1;
    rst       = r;
    en        = e;
    test_mode = tm;
    flush     = f;
    in_valid  = v & e;
    act_in    = d;
    acc = (v & e) && (mode != 2);
    if (acc) begin
      for (int dut = 0; dut < 2; dut++) begin
        for (int row = 0; row < N; row++) begin
          item.due  = ecount + (tm ? 0 : depth_of(dut, row));
          item.data = d[row*W +: W];
          exp_q[dut*N + row].push_back(item);
        end
      end
    end
    p_rst   = r;
    p_en    = e;
    p_flush = f;
    p_acc   = acc;
  endtask

  task automatic idle(input int cycles, input bit tm);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b1, tm, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare every row and status output against the model.
  task automatic monitor();
    logic [1:0] exp_state;
    exp_state = (mode == 0) ? ST_IDLE : (mode == 1) ? ST_RUN : ST_DRAIN;
    for (int dut = 0; dut < 2; dut++) begin
      check("in_ready",   in_ready_o[dut],   (mode != 2));
      check("busy",       busy_o[dut],       busy_model());
      check("drain_done", drain_done_o[dut], exp_done);
      check("fsm_state",  fsm_o[dut],        exp_state);
      for (int row = 0; row < N; row++) begin
        int k;
        k = dut*N + row;
        while (exp_q[k].size() > 0 && exp_q[k][0].due < ecount) begin
          check("row_delivered", seen[k], 1'b1);
          void'(exp_q[k].pop_front());
          seen[k] = 1'b0;
        end
        if (exp_q[k].size() > 0 && exp_q[k][0].due == ecount) begin
          check("row_valid", out_valid_o[dut][row], 1'b1);
          check("row_data",  act_out_o[dut][row*W +: W], exp_q[k][0].data);
          seen[k] = 1'b1;
        end else begin
          check("row_bubble_valid", out_valid_o[dut][row], 1'b0);
          check("row_bubble_data",  act_out_o[dut][row*W +: W], '0);
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) monitor();
    end
  end

  // Stimulus sequence.
  initial begin
    logic [TOT-1:0] vec;
    int             pending;
    rst       = 1'b1;
    en        = 1'b0;
    test_mode = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    act_in    = '0;

    repeat (3) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("reset_out_valid", out_valid_o[0], '0);
    check("reset_busy",      busy_o[0],      1'b0);
    check("reset_in_ready",  in_ready_o[0],  1'b1);

    // Single vector through the skew instance.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44332211);
    idle(6, 1'b0);

    // Diagonal wavefront: vector t carries only row t.
    // The deskew instance aligns all rows in the cycle of the last vector.
    for (int t = 0; t < N; t++) begin
      vec = '0;
      vec[t*W +: W] = 8'hD0 + 8'(t);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, vec);
    end
    @(negedge clk);
    check("deskew_align_valid", out_valid_o[1], 4'hF);
    check("deskew_align_data",  act_out_o[1],   32'hD3D2D1D0);
    idle(6, 1'b0);

    // Stall mid-stream.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, TOT'({$urandom, $urandom}));
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, TOT'({$urandom, $urandom}));
    idle(6, 1'b0);

    // Random stream with random stalls.
    for (int i = 0; i < 80; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'($urandom_range(0, 1)),
            TOT'({$urandom, $urandom}));
    end
    idle(6, 1'b0);

    // Flush after 5 vectors.
    // Input is offered throughout the drain, flush is held and one stall is inserted.
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, TOT'({$urandom, $urandom}));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, TOT'({$urandom, $urandom}));
    for (int i = 0; i < N + 4; i++) begin
      drive(1'b0, (i != 1), 1'b0, (i < 3), 1'b1, TOT'({$urandom, $urandom}));
    end
    idle(6, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(N + 2, 1'b0);
    // Flush while idle is ignored.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    idle(3, 1'b0);

    // Test mode with nothing in flight.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, {N{8'hA5}});
    @(negedge clk);
    check("test_mode_data",  act_out_o[0], {N{8'hA5}});
    check("test_mode_valid", out_valid_o[0], 4'hF);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, {N{8'hA5}});
    @(negedge clk);
    check("test_mode_idle_data", act_out_o[1], '0);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0), 1'b1, 1'b0, 1'($urandom_range(0, 1)),
            TOT'({$urandom, $urandom}));
    end
    idle(N + 1, 1'b1);
    idle(3, 1'b0);

    // Reset while draining discards everything without a completion pulse.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, TOT'({$urandom, $urandom}));
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check("post_reset_in_ready",   in_ready_o[0],   1'b1);
    check("post_reset_busy",       busy_o[1],       1'b0);
    check("post_reset_drain_done", drain_done_o[0], 1'b0);
    idle(4, 1'b0);

    // Random mix of stalls, bubbles, flushes and occasional resets.
    for (int i = 0; i < 250; i++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85), 1'b0,
            ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 60),
            TOT'({$urandom, $urandom}));
    end
    idle(N + 8, 1'b0);
    @(negedge clk);

    pending = 0;
    for (int k = 0; k < 2*N; k++) pending += exp_q[k].size();
    check("scoreboard_empty", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
